// File: rtl/rs_pkg.sv
// rs_pkg: shared types for the reservation station.
// Entry state encoding, the "operand present" tag, and the entry record.
package rs_pkg;
  typedef enum logic [1:0] {FREE, WAIT, READY, EXEC} rs_state_t;
  localparam int TAG_NONE = 0;
  localparam int RS_OP_W = 4;
  localparam int RS_TAG_W = 5;
  localparam int RS_DATA_W = 32;
  typedef struct packed {
    logic [RS_OP_W-1:0]   op;
    logic [RS_TAG_W-1:0]  qj;
    logic [RS_DATA_W-1:0] vj;
    logic [RS_TAG_W-1:0]  qk;
    logic [RS_DATA_W-1:0] vk;
    rs_state_t            state;
  } rs_entry_t;
endpackage

// File: rtl/rs_entry.sv
// rs_entry: one reservation-station slot.
// Holds its operands, snoops the CDB and steps FREE->WAIT/READY->EXEC->FREE.
module rs_entry import rs_pkg::*; #(
  parameter int TAG_W = 5,
  parameter int DATA_W = 32,
  parameter int OP_W = 4,
  parameter logic [TAG_W-1:0] MY_TAG = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc,
  input  logic [OP_W-1:0]   issue_op,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [DATA_W-1:0] issue_vk,
  input  logic              dispatch,
  input  logic              cdb_broadcast,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_val,
  output rs_state_t         state,
  output logic [OP_W-1:0]   op,
  output logic [DATA_W-1:0] vj,
  output logic [DATA_W-1:0] vk
);
  logic [TAG_W-1:0] qj, qk;
  logic cdb_hit, hit_j, hit_k, snoop_j, snoop_k;
  assign cdb_hit = cdb_broadcast && cdb_tag != TAG_W'(TAG_NONE);
  assign hit_j = cdb_hit && issue_qj == cdb_tag;
  assign hit_k = cdb_hit && issue_qk == cdb_tag;
  assign snoop_j = cdb_hit && qj == cdb_tag;
  assign snoop_k = cdb_hit && qk == cdb_tag;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FREE;
      op <= '0;
      qj <= '0;
      qk <= '0;
      vj <= '0;
      vk <= '0;
    end else if (alloc) begin
      op <= issue_op;
      qj <= hit_j ? '0 : issue_qj;
      qk <= hit_k ? '0 : issue_qk;
      vj <= hit_j ? cdb_val : issue_vj;
      vk <= hit_k ? cdb_val : issue_vk;
      state <= ((hit_j || issue_qj == '0) && (hit_k || issue_qk == '0)) ? READY : WAIT;
    end else begin
      case (state)
        WAIT: begin
          if (snoop_j) begin
            qj <= '0;
            vj <= cdb_val;
          end
          if (snoop_k) begin
            qk <= '0;
            vk <= cdb_val;
          end
          if ((snoop_j || qj == '0) && (snoop_k || qk == '0)) state <= READY;
        end
        READY: if (dispatch) state <= EXEC;
        EXEC: if (cdb_hit && cdb_tag == MY_TAG) state <= FREE;
        FREE: ;
      endcase
    end
  end
endmodule

// File: rtl/reservation_station.sv
// reservation_station: Tomasulo station with lowest-free allocation and dispatch select.
// Define RS_AGE_ORDER_EN to dispatch the oldest READY entry instead of the lowest index.
module reservation_station import rs_pkg::*; #(
  parameter int ENTRIES = 4,
  parameter int TAG_W = 5,
  parameter int DATA_W = 32,
  parameter int OP_W = 4,
  parameter int TAG_BASE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [OP_W-1:0]   issue_op,
  input  logic [TAG_W-1:0]  issue_qj,
  input  logic [TAG_W-1:0]  issue_qk,
  input  logic [DATA_W-1:0] issue_vj,
  input  logic [DATA_W-1:0] issue_vk,
  output logic [TAG_W-1:0]  issue_tag,
  input  logic              cdb_broadcast,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_val,
  output logic              ex_valid,
  input  logic              ex_ready,
  output logic [OP_W-1:0]   ex_op,
  output logic [DATA_W-1:0] ex_vj,
  output logic [DATA_W-1:0] ex_vk,
  output logic [TAG_W-1:0]  ex_tag
);
  localparam int IDX_W = $clog2(ENTRIES);
  rs_state_t state [ENTRIES];
  logic [OP_W-1:0] op [ENTRIES];
  logic [DATA_W-1:0] vj [ENTRIES];
  logic [DATA_W-1:0] vk [ENTRIES];
  logic [ENTRIES-1:0] free, ready;
  logic [IDX_W-1:0] alloc_idx, pick_idx, sel, hold_idx;
  logic transfer, fire, hold;
  for (genvar i = 0; i < ENTRIES; i++) begin : g_e
    assign free[i] = state[i] == FREE;
    assign ready[i] = state[i] == READY;
    rs_entry #(.TAG_W(TAG_W), .DATA_W(DATA_W), .OP_W(OP_W), .MY_TAG(TAG_W'(TAG_BASE + i))) u_entry (
      .clk(clk), .rst_n(rst_n),
      .alloc(transfer && alloc_idx == IDX_W'(i)),
      .issue_op(issue_op), .issue_qj(issue_qj), .issue_qk(issue_qk),
      .issue_vj(issue_vj), .issue_vk(issue_vk),
      .dispatch(fire && sel == IDX_W'(i)),
      .cdb_broadcast(cdb_broadcast), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
      .state(state[i]), .op(op[i]), .vj(vj[i]), .vk(vk[i])
    );
  end
  always_comb begin
    alloc_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) if (free[i]) alloc_idx = IDX_W'(i);
  end
`ifdef RS_AGE_ORDER_EN
  // older[i][j] set when entry i was issued before entry j
  logic [ENTRIES-1:0] older [ENTRIES];
  logic blocked;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENTRIES; i++) older[i] <= '0;
    end else if (transfer) begin
      for (int j = 0; j < ENTRIES; j++) begin
        older[alloc_idx][j] <= 1'b0;
        older[j][alloc_idx] <= j != int'(alloc_idx);
      end
    end
  end
  always_comb begin
    pick_idx = '0;
    blocked = 1'b0;
    for (int i = 0; i < ENTRIES; i++) begin
      blocked = 1'b0;
      for (int j = 0; j < ENTRIES; j++) if (ready[j] && older[j][i]) blocked = 1'b1;
      if (ready[i] && !blocked) pick_idx = IDX_W'(i);
    end
  end
`else
  always_comb begin
    pick_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) if (ready[i]) pick_idx = IDX_W'(i);
  end
`endif
  // a stalled offer keeps its entry so ex_* cannot change under the unit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold <= 1'b0;
      hold_idx <= '0;
    end else begin
      hold <= ex_valid && !ex_ready;
      hold_idx <= sel;
    end
  end
  assign sel = hold ? hold_idx : pick_idx;
  assign transfer = issue_valid && issue_ready;
  assign fire = ex_valid && ex_ready;
  assign issue_ready = |free;
  assign issue_tag = TAG_W'(TAG_BASE) + TAG_W'(alloc_idx);
  assign ex_valid = |ready;
  assign ex_op = ex_valid ? op[sel] : '0;
  assign ex_vj = ex_valid ? vj[sel] : '0;
  assign ex_vk = ex_valid ? vk[sel] : '0;
  assign ex_tag = ex_valid ? TAG_W'(TAG_BASE) + TAG_W'(sel) : '0;
endmodule

// File: tb/tb_reservation_station.sv
// tb_reservation_station: directed scenarios plus random traffic checked against
// a queue-free entry model that dispatches by issue order or index.
module tb_reservation_station;
  import rs_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic issue_valid = 1'b0, issue_ready;
  logic [3:0] issue_op = '0;
  logic [4:0] issue_qj = '0, issue_qk = '0, issue_tag;
  logic [31:0] issue_vj = '0, issue_vk = '0;
  logic cdb_broadcast = 1'b0;
  logic [4:0] cdb_tag = '0;
  logic [31:0] cdb_val = '0;
  logic ex_valid, ex_ready = 1'b0;
  logic [3:0] ex_op;
  logic [31:0] ex_vj, ex_vk;
  logic [4:0] ex_tag;
  int checks = 0, failures = 0;
  rs_entry_t m [4];
  int seq [4];
  int seq_ctr = 0;
  int hold_i = -1;

  always #5 clk = ~clk;

  reservation_station dut (
    .clk(clk), .rst_n(rst_n), .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_op(issue_op), .issue_qj(issue_qj), .issue_qk(issue_qk), .issue_vj(issue_vj),
    .issue_vk(issue_vk), .issue_tag(issue_tag), .cdb_broadcast(cdb_broadcast),
    .cdb_tag(cdb_tag), .cdb_val(cdb_val), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_op(ex_op), .ex_vj(ex_vj), .ex_vk(ex_vk), .ex_tag(ex_tag)
  );

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  function automatic int pick();
    int b = -1;
    if (hold_i >= 0) return hold_i;
    for (int i = 0; i < 4; i++)
      if (m[i].state == READY) begin
`ifdef RS_AGE_ORDER_EN
        if (b < 0 || seq[i] < seq[b]) b = i;
`else
        if (b < 0) b = i;
`endif
      end
    return b;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m[i] = '0;
      m[i].state = FREE;
      seq[i] = 0;
    end
    hold_i = -1;
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    cdb_broadcast = 1'b0;
    ex_ready = 1'b0;
  endtask

  task automatic issue(input logic [3:0] o, input logic [4:0] qj, input logic [31:0] vj,
                       input logic [4:0] qk, input logic [31:0] vk);
    issue_valid = 1'b1;
    issue_op = o;
    issue_qj = qj;
    issue_vj = vj;
    issue_qk = qk;
    issue_vk = vk;
  endtask

  task automatic bcast(input logic [4:0] t, input logic [31:0] v);
    cdb_broadcast = 1'b1;
    cdb_tag = t;
    cdb_val = v;
  endtask

  // check outputs against the model, clock once, advance the model
  task automatic tick();
    int s, fi;
    logic cdb_hit;
    rs_entry_t nm [4];
    s = pick();
    fi = -1;
    for (int i = 3; i >= 0; i--) if (m[i].state == FREE) fi = i;
    chk("issue_ready", 64'(issue_ready), 64'(fi >= 0));
    if (fi >= 0) chk("issue_tag", 64'(issue_tag), 64'(fi + 1));
    chk("ex_valid", 64'(ex_valid), 64'(s >= 0));
    if (s >= 0) begin
      chk("ex_tag", 64'(ex_tag), 64'(s + 1));
      chk("ex_op", 64'(ex_op), 64'(m[s].op));
      chk("ex_vj", 64'(ex_vj), 64'(m[s].vj));
      chk("ex_vk", 64'(ex_vk), 64'(m[s].vk));
    end
    @(posedge clk);
    cdb_hit = cdb_broadcast && cdb_tag != 5'd0;
    nm = m;
    for (int i = 0; i < 4; i++) begin
      case (m[i].state)
        WAIT: begin
          if (cdb_hit && m[i].qj == cdb_tag) begin nm[i].qj = '0; nm[i].vj = cdb_val; end
          if (cdb_hit && m[i].qk == cdb_tag) begin nm[i].qk = '0; nm[i].vk = cdb_val; end
          if (nm[i].qj == '0 && nm[i].qk == '0) nm[i].state = READY;
        end
        READY: if (s == i && ex_ready) nm[i].state = EXEC;
        EXEC: if (cdb_hit && int'(cdb_tag) == i + 1) nm[i].state = FREE;
        FREE: ;
      endcase
    end
    if (issue_valid && fi >= 0) begin
      nm[fi].op = issue_op;
      nm[fi].qj = (cdb_hit && issue_qj == cdb_tag) ? 5'd0 : issue_qj;
      nm[fi].vj = (cdb_hit && issue_qj == cdb_tag) ? cdb_val : issue_vj;
      nm[fi].qk = (cdb_hit && issue_qk == cdb_tag) ? 5'd0 : issue_qk;
      nm[fi].vk = (cdb_hit && issue_qk == cdb_tag) ? cdb_val : issue_vk;
      nm[fi].state = (nm[fi].qj == '0 && nm[fi].qk == '0) ? READY : WAIT;
      seq[fi] = ++seq_ctr;
    end
    hold_i = (s >= 0 && !ex_ready) ? s : -1;
    m = nm;
    #1;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #1;
    chk("rst_issue_ready", 64'(issue_ready), 64'd1);
    chk("rst_issue_tag", 64'(issue_tag), 64'd1);
    chk("rst_ex_valid", 64'(ex_valid), 64'd0);
    chk("rst_ex_op", 64'(ex_op), 64'd0);
    chk("rst_ex_vj", 64'(ex_vj), 64'd0);
    chk("rst_ex_vk", 64'(ex_vk), 64'd0);
    chk("rst_ex_tag", 64'(ex_tag), 64'd0);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [4:0] t0;
    logic [31:0] vj0;
    int ex_list [$];
    // single ready op dispatches next cycle
    do_reset();
    issue(4'd3, 5'd0, 32'd7, 5'd0, 32'd9);
    chk("t1_issue_tag", 64'(issue_tag), 64'd1);
    tick();
    idle();
    chk("t1_ex_valid", 64'(ex_valid), 64'd1);
    chk("t1_ex_tag", 64'(ex_tag), 64'd1);
    chk("t1_ex_vj", 64'(ex_vj), 64'd7);
    chk("t1_ex_vk", 64'(ex_vk), 64'd9);
    tick();
    // operand captured from the CDB
    do_reset();
    issue(4'd2, 5'd5, 32'd0, 5'd0, 32'd2);
    tick();
    idle();
    tick();
    tick();
    chk("t2_wait", 64'(ex_valid), 64'd0);
    bcast(5'd5, 32'h11);
    tick();
    idle();
    chk("t2_ex_valid", 64'(ex_valid), 64'd1);
    chk("t2_ex_vj", 64'(ex_vj), 64'h11);
    tick();
    // same-cycle bypass on issue
    do_reset();
    issue(4'd1, 5'd6, 32'd0, 5'd0, 32'd4);
    bcast(5'd6, 32'h22);
    tick();
    idle();
    chk("t3_ex_valid", 64'(ex_valid), 64'd1);
    chk("t3_ex_vj", 64'(ex_vj), 64'h22);
    tick();
    // fill, dispatch one, release it by its own tag
    do_reset();
    for (int i = 0; i < 4; i++) begin
      issue(4'(i), 5'd9, 32'd0, 5'd0, 32'(i));
      tick();
    end
    idle();
    chk("t4_full", 64'(issue_ready), 64'd0);
    bcast(5'd9, 32'h99);
    tick();
    idle();
    ex_ready = 1'b1;
    tick();
    idle();
    bcast(5'd1, 32'h5);
    tick();
    idle();
    chk("t4_ready_again", 64'(issue_ready), 64'd1);
    chk("t4_freed_tag", 64'(issue_tag), 64'd1);
    tick();
    // age order and stall stability
    do_reset();
    issue(4'd1, 5'd0, 32'd1, 5'd0, 32'd1);
    tick();
    issue(4'd2, 5'd20, 32'd0, 5'd0, 32'hb);
    ex_ready = 1'b1;
    tick();
    idle();
    bcast(5'd1, 32'h0);
    tick();
    idle();
    issue(4'd3, 5'd20, 32'd0, 5'd0, 32'hc);
    tick();
    idle();
    bcast(5'd20, 32'h33);
    tick();
    idle();
    t0 = ex_tag;
    vj0 = ex_vk;
`ifdef RS_AGE_ORDER_EN
    chk("t5_age_pick", 64'(ex_tag), 64'd2);
`else
    chk("t5_index_pick", 64'(ex_tag), 64'd1);
`endif
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_stable_tag", 64'(ex_tag), 64'(t0));
      chk("t5_stable_vk", 64'(ex_vk), 64'(vj0));
    end
    // asynchronous reset mid-operation
    do_reset();
    issue(4'd5, 5'd0, 32'd1, 5'd0, 32'd2);
    tick();
    idle();
    ex_ready = 1'b1;
    issue(4'd6, 5'd11, 32'd0, 5'd0, 32'd3);
    tick();
    idle();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_ex_valid", 64'(ex_valid), 64'd0);
    chk("t6_async_issue_ready", 64'(issue_ready), 64'd1);
    model_clear();
    ex_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_no_dispatch", 64'(ex_valid), 64'd0);
    rst_n = 1'b1;
    idle();
    // random traffic
    for (int c = 0; c < 400; c++) begin
      idle();
      if ($urandom_range(0, 1) == 1)
        issue(4'($urandom), ($urandom_range(0, 1) == 1) ? 5'(10 + $urandom_range(0, 2)) : 5'd0,
              $urandom, ($urandom_range(0, 2) == 0) ? 5'(10 + $urandom_range(0, 2)) : 5'd0, $urandom);
      ex_list.delete();
      for (int i = 0; i < 4; i++) if (m[i].state == EXEC) ex_list.push_back(i + 1);
      if (ex_list.size() > 0 && $urandom_range(0, 2) == 0)
        bcast(5'(ex_list[$urandom_range(0, ex_list.size() - 1)]), $urandom);
      else if ($urandom_range(0, 2) == 0)
        bcast(5'(10 + $urandom_range(0, 2)), $urandom);
      ex_ready = $urandom_range(0, 1) == 1;
      tick();
    end
    idle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
